rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter SEL_W, default 5, register select width (2**SEL_W registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports a_valid/a_sel/a_data  input  1/SEL_W/DATA_W  source A (pipeline writeback) write request.
REQ-006 SHALL have port a_ready  output  1  source A request accepted this cycle.
REQ-007 SHALL have ports b_valid/b_sel/b_data  input  1/SEL_W/DATA_W  source B (multi-cycle unit) write request.
REQ-008 SHALL have port b_ready  output  1  source B request accepted this cycle.
REQ-009 SHALL have ports issue_valid/issue_sel  input  1/SEL_W  long-latency op issued; mark destination pending.
REQ-010 SHALL have ports rs1_sel/rs2_sel  input  SEL_W each  registers read by the instruction in decode.
REQ-011 SHALL have port stall  output  1  decode must hold; a read register is pending.
REQ-012 SHALL have ports writenable/writesel/Din  output  1/SEL_W/DATA_W  register-file write port drive, registered.

Function
REQ-013 SHALL accept a request when valid and ready are both high in the same cycle; sources hold valid/sel/data stable until accepted.
REQ-014 SHALL accept at most one request per cycle; ready is combinational from valid and the priority pointer.
REQ-015 SHALL, with one source valid, grant it; with both valid, grant the source named by the priority pointer.
REQ-016 SHALL set the priority pointer to the non-granted source after every grant; with no grant the pointer holds.
REQ-017 SHALL drive writenable/writesel/Din one cycle after acceptance with the accepted sel/data; writenable low in cycles with no accept.
REQ-018 SHALL accept a request with sel 0 but keep writenable low for it (r0 hardwired zero).
REQ-019 SHALL keep a pending bitmap of 2**SEL_W bits; issue_valid sets bit issue_sel, except sel 0.
REQ-020 SHALL clear pending bit b_sel on source B acceptance; source A acceptance leaves the bitmap unchanged.
REQ-021 SHALL, on issue_valid and B acceptance hitting the same register in one cycle, leave the bit set (set wins).
REQ-022 SHALL drive stall = pending[rs1_sel] OR pending[rs2_sel], combinational from registered state; no bypass of the clearing acceptance.
REQ-023 SHALL treat issue to an already-pending register as a no-op on the bitmap.

Reset
REQ-024 SHALL, on rst_n low, immediately clear writenable, writesel, Din, pending bitmap, and set the priority pointer to A.
REQ-025 SHALL hold a_ready, b_ready low during reset; stall low since the bitmap is zero.
REQ-026 SHALL, on reset asserted mid-transfer, discard the in-flight write (no writenable after release).

Structure
REQ-027 SHALL take DATA_W, SEL_W defaults and the source-ID encoding (SRC_A=0, SRC_B=1) from shared package rf_pkg.
REQ-028 SHALL instantiate one sub-module rr_arbiter2 (2-way round-robin arbiter, pointer inside) for REQ-015/016.

Verification
REQ-029 SHALL cover: a_valid only, a_sel=1, a_data=32'h8421 -> a_ready same cycle; next cycle writenable=1, writesel=1, Din=32'h8421.
REQ-030 SHALL cover: both valid three consecutive cycles after reset, new requests each -> grants A, B, A.
REQ-031 SHALL cover: a_valid, a_sel=0, a_data=32'h1248 -> a_ready=1, writenable stays 0.
REQ-032 SHALL cover: issue_sel=3, then rs1_sel=3 -> stall=1 until cycle after B accepted with b_sel=3; then stall=0.
REQ-033 SHALL cover: issue_sel=5 and B accept b_sel=5 same cycle -> pending[5] remains 1, stall with rs2_sel=5.
REQ-034 SHALL cover: rst_n low the cycle after acceptance -> writenable 0 immediately, pending cleared, next grant with both valid goes to A.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and source identifiers for the register-file write scheduler.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer names the winner when both request.
// Grants are combinational and forced low while reset is asserted.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    src_e ptr_q, ptr_d;

    always_comb begin
        gnt_a_o = rst_n & req_a_i & (~req_b_i | (ptr_q == SRC_A));
        gnt_b_o = rst_n & req_b_i & (~req_a_i | (ptr_q == SRC_B));
    end

    // The loser of any grant gets priority next; idle cycles hold the pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_a_o)
            ptr_d = SRC_B;
        else if (gnt_b_o)
            ptr_d = SRC_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= SRC_A;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Merges pipeline writeback (A) and multi-cycle unit (B) onto one registered RF write port,
// and tracks long-latency destinations pending so decode can stall on them.
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [SEL_W-1:0]  b_sel,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [SEL_W-1:0]  issue_sel,
    input  logic [SEL_W-1:0]  rs1_sel,
    input  logic [SEL_W-1:0]  rs2_sel,
    output logic              stall,
    output logic              writenable,
    output logic [SEL_W-1:0]  writesel,
    output logic [DATA_W-1:0] Din
);

    localparam int NREG = 1 << SEL_W;

    logic              a_gnt, b_gnt;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  wsel_q, wsel_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [NREG-1:0]   pend_q, pend_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    // r0 is hardwired zero: its writes are accepted but never reach the RF.
    always_comb begin
        we_d   = 1'b0;
        wsel_d = wsel_q;
        din_d  = din_q;
        if (a_gnt) begin
            we_d   = (a_sel != '0);
            wsel_d = a_sel;
            din_d  = a_data;
        end else if (b_gnt) begin
            we_d   = (b_sel != '0);
            wsel_d = b_sel;
            din_d  = b_data;
        end
    end

    // Set is applied after clear so a same-cycle issue to the retiring register wins.
    always_comb begin
        pend_d = pend_q;
        if (b_gnt)
            pend_d[b_sel] = 1'b0;
        if (issue_valid && (issue_sel != '0))
            pend_d[issue_sel] = 1'b1;
    end

    assign stall = pend_q[rs1_sel] | pend_q[rs2_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            wsel_q <= '0;
            din_q  <= '0;
            pend_q <= '0;
        end else begin
            we_q   <= we_d;
            wsel_q <= wsel_d;
            din_q  <= din_d;
            pend_q <= pend_d;
        end
    end

    assign writenable = we_q;
    assign writesel   = wsel_q;
    assign Din        = din_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Table-driven bench for rf_write_scheduler with a write-port scoreboard and reset sequences.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_sel, b_sel, issue_sel, rs1_sel, rs2_sel;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, stall, writenable;
    logic [4:0]  writesel;
    logic [31:0] Din;

    always #5 clk = ~clk;

    rf_write_scheduler #(.DATA_W(32), .SEL_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_sel(issue_sel),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .stall(stall),
        .writenable(writenable), .writesel(writesel), .Din(Din)
    );

    typedef struct {
        logic av; logic [4:0] as; logic [31:0] ad;
        logic bv; logic [4:0] bs; logic [31:0] bd;
        logic iv; logic [4:0] isel;
        logic [4:0] r1; logic [4:0] r2;
        logic ear; logic ebr; logic est;
    } vec_t;

    typedef struct { logic we; logic [4:0] sel; logic [31:0] dat; } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic av, input logic [4:0] as, input logic [31:0] ad,
                                input logic bv, input logic [4:0] bs, input logic [31:0] bd,
                                input logic iv, input logic [4:0] isel,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ear, input logic ebr, input logic est);
        vec_t v;
        v.av = av; v.as = as; v.ad = ad; v.bv = bv; v.bs = bs; v.bd = bd;
        v.iv = iv; v.isel = isel; v.r1 = r1; v.r2 = r2;
        v.ear = ear; v.ebr = ebr; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_sel = v.as; a_data = v.ad;
        b_valid = v.bv; b_sel = v.bs; b_data = v.bd;
        issue_valid = v.iv; issue_sel = v.isel;
        rs1_sel = v.r1; rs2_sel = v.r2;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic run_vec(input string nm, input vec_t v);
        wr_t e;
        drive(v);
        @(negedge clk);
        chk({nm, ".a_ready"}, {31'd0, a_ready}, {31'd0, v.ear});
        chk({nm, ".b_ready"}, {31'd0, b_ready}, {31'd0, v.ebr});
        chk({nm, ".stall"},   {31'd0, stall},   {31'd0, v.est});
        if (v.ear)      sb.push_back('{we: (v.as != 0), sel: v.as, dat: v.ad});
        else if (v.ebr) sb.push_back('{we: (v.bs != 0), sel: v.bs, dat: v.bd});
        else            sb.push_back('{we: 1'b0, sel: 5'd0, dat: 32'd0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, ".writenable"}, {31'd0, writenable}, {31'd0, e.we});
        if (e.we) begin
            chk({nm, ".writesel"}, {27'd0, writesel}, {27'd0, e.sel});
            chk({nm, ".Din"}, Din, e.dat);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0);

        // after reset the pointer favours A
        tbl.push_back(mk(1,2,32'hAAAA, 1,4,32'hBBBB, 0,0, 0,0, 1,0,0)); // both -> A
        tbl.push_back(mk(1,6,32'hCCCC, 1,4,32'hBBBB, 0,0, 0,0, 0,1,0)); // both -> B
        tbl.push_back(mk(1,6,32'hCCCC, 1,8,32'hDDDD, 0,0, 0,0, 1,0,0)); // both -> A
        tbl.push_back(mk(0,0,0,        1,8,32'hDDDD, 0,0, 0,0, 0,1,0)); // B only
        tbl.push_back(mk(1,1,32'h8421, 0,0,0,        0,0, 0,0, 1,0,0)); // A only
        tbl.push_back(mk(1,0,32'h1248, 0,0,0,        0,0, 0,0, 1,0,0)); // r0 write dropped
        tbl.push_back(idle);                                             // ptr stays B
        tbl.push_back(mk(1,9,32'h9999, 1,10,32'h1010, 0,0, 0,0, 0,1,0)); // both -> B
        tbl.push_back(mk(1,9,32'h9999, 1,11,32'h1111, 0,0, 0,0, 1,0,0)); // both -> A
        tbl.push_back(mk(0,0,0,        1,11,32'h1111, 0,0, 0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,        1,0,32'h0BAD,  0,0, 0,0, 0,1,0)); // B to r0
        // scoreboarding of r3
        tbl.push_back(mk(0,0,0, 0,0,0,        1,3, 3,0, 0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,        0,0, 3,0, 0,0,1));
        tbl.push_back(mk(0,0,0, 1,3,32'h3333, 0,0, 3,0, 0,1,1)); // no bypass of the clear
        tbl.push_back(mk(0,0,0, 0,0,0,        0,0, 3,0, 0,0,0));
        // same-cycle issue and retire of r5: set wins
        tbl.push_back(mk(0,0,0, 1,5,32'h5555, 1,5, 0,5, 0,1,0));
        tbl.push_back(mk(0,0,0, 0,0,0,        1,5, 0,5, 0,0,1)); // re-issue is a no-op
        tbl.push_back(mk(0,0,0, 1,5,32'h5050, 0,0, 0,5, 0,1,1));
        tbl.push_back(mk(0,0,0, 0,0,0,        0,0, 0,5, 0,0,0));
        // r0 never becomes pending
        tbl.push_back(mk(0,0,0, 0,0,0,        1,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,        0,0, 0,0, 0,0,0));
        // mark r6 pending for the reset check
        tbl.push_back(mk(0,0,0, 0,0,0,        1,6, 6,0, 0,0,0));
        tbl.push_back(mk(1,12,32'hC0DE, 0,0,0, 0,0, 6,0, 1,0,1)); // ptr -> B

        rst_n = 1'b0;
        drive(mk(1,3,32'h1, 1,4,32'h2, 1,3, 3,4, 0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst.b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.writenable", {31'd0, writenable}, 32'd0);
        chk("rst.writesel", {27'd0, writesel}, 32'd0);
        chk("rst.Din", Din, 32'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("vec%0d", i), tbl[i]);

        // reset right after a visible write: outputs and pending clear at once
        rst_n = 1'b0;
        #1;
        chk("rstw.writenable", {31'd0, writenable}, 32'd0);
        chk("rstw.writesel", {27'd0, writesel}, 32'd0);
        chk("rstw.Din", Din, 32'd0);
        chk("rstw.stall", {31'd0, stall}, 32'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw.no_ghost", {31'd0, writenable}, 32'd0);
        run_vec("rstw.both", mk(1,7,32'h7A7A, 1,9,32'h9B9B, 0,0, 6,0, 1,0,0));

        // reset between acceptance and the write port update drops the write
        drive(mk(1,13,32'hBEEF, 0,0,0, 0,0, 0,0, 0,0,0));
        @(negedge clk);
        chk("rstm.a_ready", {31'd0, a_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstm.a_ready_low", {31'd0, a_ready}, 32'd0);
        drive(idle);
        @(posedge clk);
        #1;
        chk("rstm.writenable", {31'd0, writenable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstm.after_release", {31'd0, writenable}, 32'd0);
        run_vec("rstm.both", mk(1,14,32'hE0E0, 1,15,32'hF0F0, 0,0, 0,0, 1,0,0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
